// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared state encoding, default width and counter sizing for the serial adder
package serial_add_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int SA_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_e;

    // Bit counter must hold 0..WIDTH-1 and never collapse to zero bits
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: operand and result valid/ready handshakes of the serial adder
interface serial_add_ctrl_if #(parameter int WIDTH = serial_add_pkg::SA_WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, carry_out, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, carry_out, busy
    );

endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// fa_cell: 1-bit full adder built from two half-adder cells and an OR for the carry
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    logic s0, c0, c1;

    half_adder u_ha0 (.a(a),  .b(b),   .sum(s0),  .carry(c0));
    half_adder u_ha1 (.a(s0), .b(cin), .sum(sum), .carry(c1));

    // The two half-adder carries can never both be set, so OR is exact
    assign carry = c0 | c1;

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial LSB-first adder sharing one full-adder cell over WIDTH cycles
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    serial_add_ctrl_if.slave   bus
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_q;
    logic [WIDTH-1:0] shift_a_q, shift_b_q, res_q, res_d, sum_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_out_q, in_ready_q, out_valid_q, busy_q;
    logic             s, c, last;

    fa_cell u_fa (
        .a    (shift_a_q[0]),
        .b    (shift_b_q[0]),
        .cin  (carry_q),
        .sum  (s),
        .carry(c)
    );

    // Next result word (new bit enters at the MSB), counter increment and last-bit detect
    always_comb begin
        res_d = (res_q >> 1) | (WIDTH'(s) << (WIDTH - 1));
        cnt_d = cnt_q + CW'(1);
        last  = (cnt_q == CW'(WIDTH - 1));
    end

    // Controller FSM with all handshake outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            shift_a_q   <= '0;
            shift_b_q   <= '0;
            res_q       <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        shift_a_q  <= bus.a;
                        shift_b_q  <= bus.b;
                        carry_q    <= bus.cin;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    shift_a_q <= shift_a_q >> 1;
                    shift_b_q <= shift_b_q >> 1;
                    res_q     <= res_d;
                    carry_q   <= c;
                    cnt_q     <= cnt_d;
                    if (last) begin
                        sum_q       <= res_d;
                        carry_out_q <= c;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.carry_out = carry_out_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed self-checking bench for 8-bit and 1-bit serial adders
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_add_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One 8-bit add with optional backpressure; expects the controller idle on entry
    task automatic add8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic [8:0] exp, input int hold);
        int n;
        bus8.a = a; bus8.b = b; bus8.cin = ci; bus8.in_valid = 1'b1; bus8.out_ready = 1'b0;
        chk({tag, " in_ready_pre"}, 64'(bus8.in_ready), 64'd1);
        step();
        bus8.in_valid = 1'b0;
        chk({tag, " busy"}, 64'(bus8.busy), 64'd1);
        chk({tag, " in_ready_run"}, 64'(bus8.in_ready), 64'd0);
        n = 0;
        while (!bus8.out_valid && n < 40) begin
            step();
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'd8);
        chk({tag, " result"}, 64'({bus8.carry_out, bus8.sum}), 64'(exp));
        for (int i = 0; i < hold; i++) begin
            bus8.in_valid = i[0];
            bus8.a = 8'h11; bus8.b = 8'h22; bus8.cin = 1'b1;
            step();
            chk({tag, " hold_valid"}, 64'(bus8.out_valid), 64'd1);
            chk({tag, " hold_result"}, 64'({bus8.carry_out, bus8.sum}), 64'(exp));
            chk({tag, " hold_in_ready"}, 64'(bus8.in_ready), 64'd0);
        end
        bus8.in_valid = 1'b0;
        bus8.out_ready = 1'b1;
        step();
        bus8.out_ready = 1'b0;
        chk({tag, " released"}, 64'(bus8.out_valid), 64'd0);
        chk({tag, " idle"}, 64'(bus8.in_ready), 64'd1);
    endtask

    logic [7:0] ta [4] = '{8'h01, 8'h80, 8'h7F, 8'hC3};
    logic [7:0] tb [4] = '{8'h02, 8'h80, 8'h01, 8'h3C};
    logic       tc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [8:0] te [4] = '{9'h003, 9'h100, 9'h081, 9'h0FF};

    initial begin
        int  cyc, k, r, last_acc, quiet;
        logic acc;
        logic [2:0] v;
        bus8.in_valid = 0; bus8.a = 0; bus8.b = 0; bus8.cin = 0; bus8.out_ready = 0;
        bus1.in_valid = 0; bus1.a = 0; bus1.b = 0; bus1.cin = 0; bus1.out_ready = 0;
        step();
        step();
        chk("rst in_ready", 64'(bus8.in_ready), 64'd1);
        chk("rst out_valid", 64'(bus8.out_valid), 64'd0);
        chk("rst busy", 64'(bus8.busy), 64'd0);
        chk("rst result", 64'({bus8.carry_out, bus8.sum}), 64'd0);
        rst = 1'b0;
        step();

        add8("zero", 8'h00, 8'h00, 1'b0, 9'h000, 0);
        add8("ff_01", 8'hFF, 8'h01, 1'b0, 9'h100, 0);
        add8("a5_5a_c1", 8'hA5, 8'h5A, 1'b1, 9'h100, 0);
        add8("a5_5a_c0", 8'hA5, 8'h5A, 1'b0, 9'h0FF, 0);
        add8("bp", 8'h3C, 8'h4B, 1'b1, 9'h088, 5);

        bus8.a = 8'h77; bus8.b = 8'h99; bus8.cin = 1'b1; bus8.in_valid = 1'b1;
        step();
        bus8.in_valid = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        #1;
        chk("mid_rst in_ready", 64'(bus8.in_ready), 64'd1);
        chk("mid_rst out_valid", 64'(bus8.out_valid), 64'd0);
        chk("mid_rst busy", 64'(bus8.busy), 64'd0);
        step();
        rst = 1'b0;
        quiet = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            quiet += int'(bus8.out_valid);
        end
        chk("mid_rst no_result", 64'(quiet), 64'd0);
        add8("post_rst", 8'h12, 8'h34, 1'b0, 9'h046, 0);

        cyc = 0; k = 0; r = 0; last_acc = 0;
        bus8.a = ta[0]; bus8.b = tb[0]; bus8.cin = tc[0];
        bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
        while (r < 4 && cyc < 100) begin
            acc = bus8.in_ready;
            step();
            cyc++;
            if (acc && k < 4) begin
                if (k > 0) chk("b2b spacing", 64'(cyc - last_acc), 64'd10);
                last_acc = cyc;
                k++;
                if (k < 4) begin
                    bus8.a = ta[k]; bus8.b = tb[k]; bus8.cin = tc[k];
                end else bus8.in_valid = 1'b0;
            end
            if (bus8.out_valid) begin
                chk("b2b result", 64'({bus8.carry_out, bus8.sum}), 64'(te[r]));
                r++;
            end
        end
        chk("b2b count", 64'(r), 64'd4);
        bus8.in_valid = 1'b0; bus8.out_ready = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            bus1.a = v[2]; bus1.b = v[1]; bus1.cin = v[0]; bus1.in_valid = 1'b1;
            step();
            bus1.in_valid = 1'b0;
            chk("w1 not_yet", 64'(bus1.out_valid), 64'd0);
            step();
            chk("w1 valid", 64'(bus1.out_valid), 64'd1);
            chk("w1 result", 64'({bus1.carry_out, bus1.sum}), 64'(v[2] + v[1] + v[0]));
            bus1.out_ready = 1'b1;
            step();
            bus1.out_ready = 1'b0;
            chk("w1 idle", 64'(bus1.in_ready), 64'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial addition controller that reuses a single full-adder cell. The cell is built from two instances of the existing half-adder cell (a, b -> sum, carry). The controller adds two WIDTH-bit operands LSB-first over WIDTH cycles. It accepts operands through a valid/ready handshake and returns the sum and carry-out through a second valid/ready handshake. It is the area-minimal adder option for slow control-path arithmetic.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 1..32)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair a/b is valid
in_ready  output  1  controller can accept operands (IDLE only)
a  input  WIDTH  operand A, sampled on in_valid && in_ready
b  input  WIDTH  operand B, sampled on in_valid && in_ready
cin  input  1  carry-in, sampled with a/b
out_valid  output  1  sum/carry_out are valid
out_ready  input  1  downstream accepts the result
sum  output  WIDTH  a + b + cin, low WIDTH bits
carry_out  output  1  bit WIDTH of a + b + cin
busy  output  1  high in RUN

Behaviour:
- Interface decision: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - sum=0; carry_out=0.
  - Internal shift registers, carry flop and bit counter all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: load shift_a<=a, shift_b<=b, carry_q<=cin, cnt<=0, then go to RUN.
  - in_valid is ignored while the controller is not in IDLE; there is no queuing.
- RUN, one bit per cycle:
  - The cell computes {c, s} = shift_a[0] + shift_b[0] + carry_q.
  - shift_a and shift_b shift right. The result shift register takes s into its MSB and shifts right.
  - carry_q<=c; cnt<=cnt+1.
  - When cnt==WIDTH-1: transfer the result to sum, set carry_out<=c, out_valid<=1, and go to DONE.
- DONE:
  - out_valid=1. sum and carry_out are held stable until out_ready.
  - On out_ready: out_valid<=0, in_ready<=1, go to IDLE.
- Latency:
  - in handshake on edge N gives out_valid=1 after edge N+WIDTH.
  - Minimum spacing between accepted operand pairs is WIDTH+2 cycles (includes the IDLE cycle).
- Outputs are registered. No combinational path from in_valid or out_ready to any output except through the state register.
- sum and carry_out keep their last value after the DONE handshake. They are defined only while out_valid=1.
- Counter width is max(1, clog2(WIDTH)).
- WIDTH=1: RUN lasts exactly one cycle.
- out_ready held high in DONE: a one-cycle DONE, then IDLE.
- in_valid asserted in the same cycle as the DONE->IDLE transition: not accepted. Operands are accepted on the next cycle, in IDLE.
- rst asserted mid-RUN or mid-DONE: outputs return to reset values immediately (asynchronous). The partial result is discarded and no out_valid pulse is produced.
- Arithmetic is unsigned modulo 2^WIDTH, with carry_out as the overflow bit.

Decomposition:
- Shared package serial_add_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - default width constant SA_WIDTH=8.
- Sub-module fa_cell: a 1-bit full adder built from two half-adder instances plus an OR for carry. Its ports are a, b, cin, sum, carry.
- serial_add_ctrl instantiates exactly one fa_cell.

Test Plan:
1. WIDTH=8: a=0x00, b=0x00, cin=0 -> sum=0x00, carry_out=0. out_valid rises exactly 8 cycles after the handshake.
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, carry_out=1. Then a=0xA5, b=0x5A, cin=1 -> sum=0x00, carry_out=1. Then a=0xA5, b=0x5A, cin=0 -> sum=0xFF, carry_out=0.
3. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> sum, carry_out and out_valid remain stable. in_ready stays 0 and in_valid pulses are ignored. out_ready=1 -> IDLE next cycle.
4. Reset mid-RUN: assert rst 3 cycles into RUN -> in_ready=1, out_valid=0, busy=0 immediately. No result is emitted. A following add of 0x12+0x34 -> 0x46, carry_out=0.
5. Back-to-back: keep in_valid=1 and out_ready=1 continuously with a new operand pair each acceptance -> one acceptance every 10 cycles, all results correct.
6. WIDTH=1 build: run all 8 combinations of a, b, cin -> {carry_out, sum} = a+b+cin, with out_valid 1 cycle after acceptance.
